// File: rtl/hex_display_pkg.sv
// Shared constants for the multiplexed hex display: active-high glyphs and index sizing.
package hex_display_pkg;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_A     = 7'b1110111;
   localparam logic [6:0] SEG_B     = 7'b0011111;
   localparam logic [6:0] SEG_C     = 7'b1001110;
   localparam logic [6:0] SEG_D     = 7'b0111101;
   localparam logic [6:0] SEG_E     = 7'b1001111;
   localparam logic [6:0] SEG_F     = 7'b1000111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // A single-digit display still needs a 1-bit index register.
   function automatic int idx_width(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational nibble to active-high 7-segment glyph, bit 6 = segment a.
module hex7seg_dec
   import hex_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   // glyph lookup
   always_comb begin
      glyph = SEG_BLANK;
      case (nibble)
         4'h0:    glyph = SEG_0;
         4'h1:    glyph = SEG_1;
         4'h2:    glyph = SEG_2;
         4'h3:    glyph = SEG_3;
         4'h4:    glyph = SEG_4;
         4'h5:    glyph = SEG_5;
         4'h6:    glyph = SEG_6;
         4'h7:    glyph = SEG_7;
         4'h8:    glyph = SEG_8;
         4'h9:    glyph = SEG_9;
         4'hA:    glyph = SEG_A;
         4'hB:    glyph = SEG_B;
         4'hC:    glyph = SEG_C;
         4'hD:    glyph = SEG_D;
         4'hE:    glyph = SEG_E;
         4'hF:    glyph = SEG_F;
         default: glyph = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/hex_display_mux.sv
// N-digit multiplexed hex display with tear-free loading and leading-zero blanking.
// Optional PWM dimming of the anodes when HEX_DISPLAY_MUX_BRIGHTNESS_EN is defined.
module hex_display_mux
   import hex_display_pkg::*;
#(
   parameter int DIGITS           = 4,
   parameter int DIV_LOG2         = 16,
   parameter bit ANODE_ACTIVE_LOW = 1'b0,
   parameter bit SEG_ACTIVE_LOW   = 1'b0
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   data,
   input  logic                  data_valid,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  blank_lz,
`ifdef HEX_DISPLAY_MUX_BRIGHTNESS_EN
   input  logic [3:0]            brightness,
`endif
   output logic [DIGITS-1:0]     anodes,
   output logic [6:0]            segments,
   output logic                  dp,
   output logic                  frame_done
);

   localparam int                IW       = idx_width(DIGITS);
   localparam logic [IW-1:0]     LAST_IDX = IW'(DIGITS - 1);
   localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{ANODE_ACTIVE_LOW}};
   localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};

   logic [DIV_LOG2-1:0] presc_r;
   logic [IW-1:0]       idx_r;
   logic [4*DIGITS-1:0] disp_r, pend_data_r;
   logic [DIGITS-1:0]   disp_dp_r, pend_dp_r;
   logic                pend_r;
   logic                tick_s, boundary_s, blank_s, dp_s;
   logic [DIGITS-1:0]   lz_s, an_s;
   logic [3:0]          nibble_s;
   logic [6:0]          glyph_s, seg_s;

   assign tick_s     = &presc_r;
   assign boundary_s = tick_s && (idx_r == LAST_IDX);
   assign nibble_s   = disp_r[{idx_r, 2'b00} +: 4];

   hex7seg_dec u_dec (
      .nibble (nibble_s),
      .glyph  (glyph_s)
   );

   // prescaler and digit index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_r <= '0;
         idx_r   <= '0;
      end else begin
         presc_r <= presc_r + 1'b1;
         if (tick_s) begin
            idx_r <= boundary_s ? '0 : idx_r + 1'b1;
         end
      end
   end

   // Strobes are staged in pend and only reach disp at a frame boundary;
   // a strobe on the boundary tick itself bypasses the staging register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_r      <= '0;
         disp_dp_r   <= '0;
         pend_data_r <= '0;
         pend_dp_r   <= '0;
         pend_r      <= 1'b0;
      end else if (boundary_s && data_valid) begin
         disp_r    <= data;
         disp_dp_r <= dp_in;
         pend_r    <= 1'b0;
      end else if (boundary_s && pend_r) begin
         disp_r    <= pend_data_r;
         disp_dp_r <= pend_dp_r;
         pend_r    <= 1'b0;
      end else if (data_valid) begin
         pend_data_r <= data;
         pend_dp_r   <= dp_in;
         pend_r      <= 1'b1;
      end
   end

   // lz_s[k]: nibbles k..DIGITS-1 of the displayed value are all zero
   always_comb begin
      lz_s = '0;
      for (int k = 0; k < DIGITS; k++) begin
         lz_s[k] = ((disp_r >> (4 * k)) == '0);
      end
   end

   assign blank_s = blank_lz && (idx_r != '0) && lz_s[idx_r];

   // active-high digit view before polarity and registering
   always_comb begin
      an_s         = '0;
      an_s[idx_r]  = 1'b1;
`ifdef HEX_DISPLAY_MUX_BRIGHTNESS_EN
      if (presc_r[DIV_LOG2-1 -: 4] >= brightness) begin
         an_s = '0;
      end else begin
         an_s = an_s;
      end
`endif
      if (blank_s) begin
         seg_s = SEG_BLANK;
         dp_s  = 1'b0;
      end else begin
         seg_s = glyph_s;
         dp_s  = disp_dp_r[idx_r];
      end
   end

   // output register, reset to the inactive pin level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         anodes     <= AN_OFF;
         segments   <= SEG_OFF;
         dp         <= SEG_ACTIVE_LOW;
         frame_done <= 1'b0;
      end else begin
         anodes     <= an_s ^ AN_OFF;
         segments   <= seg_s ^ SEG_OFF;
         dp         <= dp_s ^ SEG_ACTIVE_LOW;
         frame_done <= boundary_s;
      end
   end

endmodule

// File: tb/tb_hex_display_mux.sv
// Self-checking bench: a 4-digit active-high and a 6-digit active-low display against a slot-based reference model.
`timescale 1ns/1ps
module tb_hex_display_mux;

   logic        clk    = 1'b0;
   logic        clk_en = 1'b1;
   logic        rst_n  = 1'b1;
   logic        chk_en = 1'b0;
   logic [15:0] data4  = 16'h0000;
   logic [23:0] data6  = 24'h000000;
   logic [3:0]  dp4    = 4'h0;
   logic [5:0]  dp6    = 6'h00;
   logic        dv     = 1'b0;
   logic        blank_lz = 1'b0;
   logic [3:0]  an4;
   logic [5:0]  an6;
   logic [6:0]  seg4, seg6;
   logic        dpo4, dpo6, fd4, fd6;

`ifdef HEX_DISPLAY_MUX_BRIGHTNESS_EN
   logic [3:0]  bright = 4'd4;
   localparam int BR = 4;
`else
   localparam int BR = 16;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   hex_display_mux #(.DIGITS(4), .DIV_LOG2(4), .ANODE_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)) u4 (
      .clk(clk), .rst_n(rst_n), .data(data4), .data_valid(dv), .dp_in(dp4), .blank_lz(blank_lz),
`ifdef HEX_DISPLAY_MUX_BRIGHTNESS_EN
      .brightness(bright),
`endif
      .anodes(an4), .segments(seg4), .dp(dpo4), .frame_done(fd4));

   hex_display_mux #(.DIGITS(6), .DIV_LOG2(4), .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) u6 (
      .clk(clk), .rst_n(rst_n), .data(data6), .data_valid(dv), .dp_in(dp6), .blank_lz(blank_lz),
`ifdef HEX_DISPLAY_MUX_BRIGHTNESS_EN
      .brightness(bright),
`endif
      .anodes(an6), .segments(seg6), .dp(dpo6), .frame_done(fd6));

   initial forever begin
      #5;
      if (clk_en) clk = ~clk;
   end

   // ---------------- reference model ----------------
   logic [6:0]  glyph_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                   7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                   7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                   7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
   int          nd [2] = '{4, 6};
   int          mt;
   logic [23:0] m_disp [2];
   logic [23:0] m_pdata [2];
   logic [5:0]  m_ddp [2];
   logic [5:0]  m_pdp [2];
   logic        m_pend [2];
   logic [5:0]  e_an [2];
   logic [7:0]  e_sd [2];
   logic        e_fd [2];

   // Each digit owns 16 consecutive cycles; a frame is 16*d cycles counted from reset.
   function automatic logic f_bnd(input int d, input int t);
      return ((t % 16) == 15) && (((t / 16) % d) == d - 1);
   endfunction

   function automatic logic [5:0] f_an(input int d, input int t);
      if ((t % 16) >= BR) return 6'd0;
      return 6'd1 << ((t / 16) % d);
   endfunction

   function automatic logic [7:0] f_segdp(input int d, input int t, input logic [23:0] disp,
                                          input logic [5:0] ddp, input logic blz);
      int slot;
      slot = (t / 16) % d;
      if (blz && slot > 0 && (disp >> (4 * slot)) == 24'd0) return 8'h00;
      return {glyph_tab[disp[4*slot +: 4]], ddp[slot]};
   endfunction

   function automatic logic [23:0] in_data(input int i);
      return (i == 0) ? {8'h00, data4} : data6;
   endfunction

   function automatic logic [5:0] in_dp(input int i);
      return (i == 0) ? {2'b00, dp4} : dp6;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mt   <= 0;
         e_an[0] <= 6'h00; e_an[1] <= 6'h3F;
         e_sd[0] <= 8'h00; e_sd[1] <= 8'hFF;
         for (int i = 0; i < 2; i++) begin
            m_disp[i] <= '0; m_pdata[i] <= '0; m_ddp[i] <= '0; m_pdp[i] <= '0;
            m_pend[i] <= 1'b0; e_fd[i] <= 1'b0;
         end
      end else begin
         mt <= mt + 1;
         for (int i = 0; i < 2; i++) begin
            e_an[i] <= f_an(nd[i], mt) ^ ((i == 1) ? 6'h3F : 6'h00);
            e_sd[i] <= f_segdp(nd[i], mt, m_disp[i], m_ddp[i], blank_lz) ^ ((i == 1) ? 8'hFF : 8'h00);
            e_fd[i] <= f_bnd(nd[i], mt);
            if (f_bnd(nd[i], mt) && dv) begin
               m_disp[i] <= in_data(i); m_ddp[i] <= in_dp(i); m_pend[i] <= 1'b0;
            end else if (f_bnd(nd[i], mt) && m_pend[i]) begin
               m_disp[i] <= m_pdata[i]; m_ddp[i] <= m_pdp[i]; m_pend[i] <= 1'b0;
            end else if (dv) begin
               m_pdata[i] <= in_data(i); m_pdp[i] <= in_dp(i); m_pend[i] <= 1'b1;
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 30) $display("FAIL %s t=%0d: got %h, expected %h", nm, mt, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("an4",  32'(an4),          32'(e_an[0][3:0]));
         check("sd4",  32'({seg4, dpo4}), 32'(e_sd[0]));
         check("fd4",  32'(fd4),          32'(e_fd[0]));
         check("an6",  32'(an6),          32'(e_an[1]));
         check("sd6",  32'({seg6, dpo6}), 32'(e_sd[1]));
         check("fd6",  32'(fd6),          32'(e_fd[1]));
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_until(input int e);
      int g;
      g = 0;
      while (mt < e && g < 5000) begin
         @(negedge clk);
         g++;
      end
      check("wait_bound", 32'(mt >= e), 32'd1);
   endtask

   task automatic load(input logic [15:0] v4, input logic [3:0] p4);
      data4 = v4; dp4 = p4; data6 = 24'($urandom); dp6 = 6'($urandom);
      dv = 1'b1;
      step();
      dv = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      #1 rst_n = 1'b0;
      #2 chk_en = 1'b1;
      repeat (2) step();
      #1 rst_n = 1'b1;

      load(16'h1234, 4'h0);
      check("rst_an4",  32'(an4),  32'h1);
      check("rst_seg4", 32'(seg4), 32'h7E);
      check("rst_an6",  32'(an6),  32'h3E);
      check("rst_seg6", 32'(seg6), 32'h01);
      wait_until(64);  check("fd_first", 32'(fd4), 32'd1);
      wait_until(65);  check("d0_4", 32'(seg4), 32'h33); check("d0_an", 32'(an4), 32'h1);
      wait_until(81);  check("d1_3", 32'(seg4), 32'h79); check("d1_an", 32'(an4), 32'h2);

      wait_until(100); blank_lz = 1'b1; load(16'h0050, 4'b0101);
      wait_until(129); check("lz_d0", 32'(seg4), 32'h7E); check("lz_dp0", 32'(dpo4), 32'd1);
      wait_until(145); check("lz_d1", 32'(seg4), 32'h5B);
      wait_until(161); check("lz_d2", 32'(seg4), 32'h00); check("lz_dp2", 32'(dpo4), 32'd0);
      wait_until(200); load(16'h0000, 4'h0);
      wait_until(257); check("zero_d0", 32'(seg4), 32'h7E);
      wait_until(273); check("zero_d1", 32'(seg4), 32'h00);

      wait_until(300); blank_lz = 1'b0; load(16'hAAAA, 4'h0);
      wait_until(310); load(16'hBBBB, 4'h0);
      wait_until(321); check("lastwin_d0", 32'(seg4), 32'h1F);
      wait_until(369); check("lastwin_d3", 32'(seg4), 32'h1F);

      wait_until(447); load(16'hFFFF, 4'h0);
      wait_until(449); check("bypass_d0", 32'(seg4), 32'h47);

      wait_until(470);
      clk_en = 1'b0;
      #20 rst_n = 1'b0;
      #1;
      check("arst_an4", 32'(an4), 32'h0);
      check("arst_seg4", 32'({seg4, dpo4}), 32'h00);
      check("arst_fd4", 32'(fd4), 32'd0);
      check("arst_an6", 32'(an6), 32'h3F);
      check("arst_seg6", 32'({seg6, dpo6}), 32'hFF);
      #10 rst_n = 1'b1;
      #4 clk_en = 1'b1;
      wait_until(1);  check("post_d0", 32'(seg4), 32'h7E);
      wait_until(63); check("post_fd_lo", 32'(fd4), 32'd0);
      wait_until(64); check("post_fd_hi", 32'(fd4), 32'd1);

      repeat (3000) begin
         step();
         dv    = ($urandom_range(0, 7) == 0);
         data4 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         data6 = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 4095)) : 24'($urandom);
         dp4   = 4'($urandom);
         dp6   = 6'($urandom);
         if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
      end
      dv = 1'b0;
      step();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hex_display_mux.md
Name: hex_display_mux

Overview:
- Parametrised N-digit multiplexed 7-segment hex display driver; successor of the fixed 4-digit display path.
- Integrates the scan prescaler, so no external clock divider is needed; runs on the system clock.
- Adds a data_valid load strobe, tear-free frame-boundary update, leading-zero blanking, per-digit decimal points and output polarity selection.
- Sits between CPU output register (data_out) and board pins.

Parameters:
- DIGITS, 4, number of digits; data width 4*DIGITS; must be >= 1.
- DIV_LOG2, 16, scan tick every 2^DIV_LOG2 clk cycles; must be >= 4.
- ANODE_ACTIVE_LOW, 0, 1 inverts anodes outputs.
- SEG_ACTIVE_LOW, 0, 1 inverts segments and dp outputs.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- data  in  4*DIGITS  hex value; nibble k maps to digit k; digit 0 is the least significant
- data_valid  in  1  single-cycle load strobe for data and dp_in
- dp_in  in  DIGITS  decimal point per digit, captured with data
- blank_lz  in  1  leading-zero blanking enable; level, sampled live
- anodes  out  DIGITS  one-hot digit enable
- segments  out  7  {a,b,c,d,e,f,g}, bit 6 = a
- dp  out  1  decimal point of the active digit
- frame_done  out  1  one-cycle pulse per completed scan frame

Behaviour:
- Prescaler: DIV_LOG2-bit up-counter, free-running, wraps. tick = counter all-ones.
- Digit index idx: 0..DIGITS-1. Increments on tick. Wraps DIGITS-1 -> 0 (frame boundary).
- Load path:
  - data_valid writes pend_data/pend_dp and sets the pend flag; a later strobe overwrites (last write wins).
  - At the frame boundary with pend set: disp <= pend and pend clears.
  - data_valid in the same cycle as the boundary tick: incoming data goes straight to disp and pend clears (bypass).
  - The displayed value never changes mid-frame.
- Decoder: standard hex glyphs, active-high internally. Examples: 0=1111110, 1=0110000, 4=0110011, 5=1011011, A=1110111, b=0011111, F=1000111.
- Leading-zero blank: digit k>0 shows 0000000 with dp off when blank_lz=1 and disp nibbles k..DIGITS-1 are all zero. Digit 0 is never blanked.
- Outputs registered, latency 1 clk:
  - anodes = onehot(idx), segments = glyph(disp[idx]), dp = disp_dp[idx].
  - Polarity parameters apply after the register.
- frame_done: registered; high exactly one cycle, the cycle after the boundary tick.
- Reset (async, no clock required):
  - prescaler=0, idx=0, disp=0, disp_dp=0, pend=0.
  - anodes/segments/dp at inactive level; frame_done=0.
  - First clk edge after release drives digit 0 showing '0'.
- DIGITS=1: every tick is a frame boundary.

Optional Feature:
- Macro: HEX_DISPLAY_MUX_BRIGHTNESS_EN.
- Defined:
  - Adds input brightness[3:0].
  - Anodes are active only while prescaler[DIV_LOG2-1 -: 4] < brightness; otherwise all anodes are inactive.
  - 0 = dark, 15 = 15/16 duty. Segments are unaffected.
- Undefined: port absent; anodes active for the full digit slot.

Decomposition:
- Package hex_display_pkg: 7-bit glyph constants 0-F, SEG_BLANK constant, localparam-width helper for the idx counter.
- Sub-module hex7seg_dec: combinational nibble -> 7-bit glyph, active-high.
- Prescaler, idx, load path and output register stay in hex_display_mux.

Test Plan (DIV_LOG2=4, DIGITS=4 unless noted):
- Reset, data=16'h1234 with data_valid, blank_lz=0.
  - After the first boundary, anodes cycle 0001,0010,0100,1000, 16 clk each.
  - Segments 0110011,1111001,1101101,0110000.
  - frame_done pulses once per 64 clk.
- data=16'h0050, blank_lz=1.
  - Digits 3,2 show 0000000; digit1 shows 1011011; digit0 shows 1111110.
  - data=16'h0000: only digit0 shows '0'.
- Strobe 16'hAAAA then 16'hBBBB within one frame: next frame shows only B (0011111) on all digits; A never appears.
- data_valid coincident with the boundary tick, value 16'hFFFF: digit 0 of the immediately following slot shows 1000111.
- rst_n asserted mid-frame with clk stopped:
  - Outputs go inactive immediately.
  - After release, digit 0 shows 1111110 and frame_done stays 0 until the first boundary.
- ANODE_ACTIVE_LOW=1, SEG_ACTIVE_LOW=1, DIGITS=6: anodes = ~onehot over 6 digits; digit '0' drives segments=0000001.
- With HEX_DISPLAY_MUX_BRIGHTNESS_EN and brightness=4: anode active 4 of 16 cycles per slot.
